// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter that shares one async-FIFO write port among NUM_REQ producers.
// Lives entirely in the w_clk domain and honours the FIFO full flag.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                         w_clk,
    input  logic                         w_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_w_en,
    output logic [WIDTH-1:0]             fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic [15:0]                  stall_cnt
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned STL_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_d;
    logic [ID_W-1:0]    pick;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [STL_W-1:0]   stall_d;
    logic               accept;
    logic [WIDTH-1:0]   data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    // First valid requester searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        logic        found;
        pick  = grant_id;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[ID_W'(idx)]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Next-state and write-port outputs; beats pass straight through in GRANT.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_id;
        beat_cnt_d = beat_cnt_q;
        stall_d    = stall_cnt;
        accept     = 1'b0;
        req_ready  = '0;
        fifo_w_en  = 1'b0;
        fifo_data  = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d    = pick;
                    rr_ptr_d   = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                accept = req_valid[grant_id] && !fifo_full;
                if (req_valid[grant_id] && fifo_full && (stall_cnt != {STL_W{1'b1}})) begin
                    stall_d = stall_cnt + STL_W'(1);
                end
                if (accept) begin
                    req_ready[grant_id] = 1'b1;
                    fifo_w_en           = 1'b1;
                    fifo_data           = data_arr[grant_id];
                    beat_cnt_d          = beat_cnt_q + CNT_W'(1);
                    // Packet end or burst cap hands the port back for one arbitration cycle.
                    if (req_last[grant_id] || (beat_cnt_d == CNT_W'(MAX_BURST))) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            grant_id   <= '0;
            stall_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_id   <= grant_d;
            stall_cnt  <= stall_d;
        end
    end

    assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int IW = $clog2(N);

    logic           w_clk;
    logic           w_rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_w_en;
    logic [W-1:0]   fifo_data;
    logic [IW-1:0]  grant_id;
    logic           busy;
    logic [15:0]    stall_cnt;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_w_en (fifo_w_en),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int checks = 0;
    int errors = 0;

    // producer side: pending beats per requester, and whether the head beat is on the bus
    logic [W-1:0] q_data [N][$];
    bit           q_last [N][$];
    bit           present [N];
    int           pct;
    bit           rand_full;
    int           full_lo, full_hi;
    int           cyc;

    // reference model state
    bit m_busy;
    int m_gid, m_rr, m_stall;
    int m_beats;

    // observed write log
    int           wr_gid [$];
    int           wr_cyc [$];
    logic [W-1:0] wr_dat [$];
    bit           busy_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_gid   = 0;
        m_rr    = N - 1;
        m_stall = 0;
        m_beats = 0;
    endtask

    task automatic clear_logs();
        wr_gid.delete();
        wr_cyc.delete();
        wr_dat.delete();
        busy_log.delete();
        cyc = 0;
    endtask

    task automatic clear_tb();
        for (int i = 0; i < N; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            present[i] = 1'b0;
        end
        pct       = 100;
        rand_full = 1'b0;
        full_lo   = 1;
        full_hi   = 0;
    endtask

    // Asserts reset at the current time, checks outputs react immediately, then releases.
    task automatic reset_dut();
        w_rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wen", 32'(fifo_w_en), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_data", 32'(fifo_data), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        model_reset();
        @(negedge w_clk);
        w_rst = 1'b0;
        clear_logs();
    endtask

    task automatic push_pkt(input int r, input int len, input logic [W-1:0] base, input bit with_last);
        for (int k = 0; k < len; k++) begin
            q_data[r].push_back(base + W'(k));
            q_last[r].push_back(with_last && (k == len - 1));
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (!present[i] && (q_data[i].size() > 0) && ($urandom_range(99) < pct))
                present[i] = 1'b1;
            req_valid[i]        = present[i];
            req_last[i]         = present[i] ? q_last[i][0] : 1'b0;
            req_data[i*W +: W]  = present[i] ? q_data[i][0] : W'($urandom);
        end
        if (cyc >= full_lo && cyc <= full_hi) fifo_full = 1'b1;
        else if (rand_full)                   fifo_full = ($urandom_range(3) == 0);
        else                                  fifo_full = 1'b0;
    endtask

    // Compare one cycle against the model, then advance model and producers across the edge.
    task automatic eval_cycle();
        logic [N-1:0] e_ready;
        logic [W-1:0] e_data;
        bit           acc;
        int           g;
        bit           found;
        #1;
        acc     = m_busy && req_valid[m_gid] && !fifo_full;
        e_ready = acc ? (N'(1) << m_gid) : '0;
        e_data  = acc ? q_data[m_gid][0] : '0;
        chk("ready", 32'(req_ready), 32'(e_ready));
        chk("w_en", 32'(fifo_w_en), 32'(acc));
        chk("data", 32'(fifo_data), 32'(e_data));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        busy_log.push_back(busy);
        if (fifo_w_en) begin
            wr_gid.push_back(int'(grant_id));
            wr_cyc.push_back(cyc);
            wr_dat.push_back(fifo_data);
        end
        g = m_gid;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && req_valid[(m_rr + k) % N]) begin
                    found = 1'b1;
                    m_gid = (m_rr + k) % N;
                end
            end
            if (found) begin
                m_rr    = m_gid;
                m_beats = 0;
                m_busy  = 1'b1;
            end
        end else begin
            if (req_valid[m_gid] && fifo_full && m_stall < 65535) m_stall++;
            if (acc) begin
                m_beats++;
                if (req_last[m_gid] || m_beats == MB) m_busy = 1'b0;
            end
        end
        @(posedge w_clk);
        if (acc) begin
            void'(q_data[g].pop_front());
            void'(q_last[g].pop_front());
            present[g] = 1'b0;
        end
        cyc++;
        @(negedge w_clk);
    endtask

    task automatic step();
        drive_inputs();
        eval_cycle();
    endtask

    function automatic bit all_drained();
        for (int i = 0; i < N; i++)
            if (q_data[i].size() > 0 || present[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_drained(input int max_cyc);
        int n;
        n = 0;
        while (!all_drained() && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(all_drained()), 32'h1);
        repeat (2) step();
    endtask

    initial begin
        int exp_t3 [11];
        exp_t3 = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 1, 1};
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        w_rst     = 1'b0;
        clear_tb();
        clear_logs();
        model_reset();
        @(negedge w_clk);

        // single requester, 3-beat packet
        reset_dut();
        push_pkt(2, 3, 8'hA1, 1'b1);
        run_until_drained(20);
        chk("t1_count", 32'(wr_gid.size()), 32'd3);
        if (wr_gid.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("t1_gid", 32'(wr_gid[k]), 32'd2);
                chk("t1_cyc", 32'(wr_cyc[k]), 32'(k + 1));
                chk("t1_dat", 32'(wr_dat[k]), 32'(8'hA1 + k));
            end
        end
        chk("t1_busy_drop", 32'(busy_log[4]), 32'h0);

        // round robin, 1-beat packets from everyone
        clear_tb();
        reset_dut();
        for (int r = 0; r < N; r++) begin
            push_pkt(r, 1, W'(8'h10 * r), 1'b1);
            push_pkt(r, 1, W'(8'h10 * r + 8), 1'b1);
        end
        run_until_drained(40);
        chk("t2_count", 32'(wr_gid.size()), 32'd8);
        if (wr_gid.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t2_gid", 32'(wr_gid[k]), 32'(k % N));
                chk("t2_cyc", 32'(wr_cyc[k]), 32'(2 * k + 1));
            end
        end

        // burst limit: req 1 without last, req 3 waiting
        clear_tb();
        reset_dut();
        push_pkt(1, 10, 8'h50, 1'b0);
        push_pkt(3, 1, 8'hC3, 1'b1);
        run_until_drained(40);
        chk("t3_count", 32'(wr_gid.size()), 32'd11);
        if (wr_gid.size() == 11) begin
            for (int k = 0; k < 11; k++) chk("t3_gid", 32'(wr_gid[k]), 32'(exp_t3[k]));
            chk("t3_cyc_r3", 32'(wr_cyc[4]), 32'd6);
        end

        // backpressure: full for cycles 3..7 mid-burst
        clear_tb();
        reset_dut();
        push_pkt(0, 4, 8'hB1, 1'b1);
        full_lo = 3;
        full_hi = 7;
        run_until_drained(40);
        chk("t4_count", 32'(wr_gid.size()), 32'd4);
        if (wr_gid.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t4_dat", 32'(wr_dat[k]), 32'(8'hB1 + k));
            chk("t4_cyc2", 32'(wr_cyc[2]), 32'd8);
        end
        chk("t4_stall", 32'(stall_cnt), 32'd5);

        // reset mid-burst after 2nd beat
        clear_tb();
        reset_dut();
        push_pkt(2, 4, 8'hD1, 1'b1);
        repeat (3) step();
        drive_inputs();
        #1;
        chk("t5_pre_wen", 32'(fifo_w_en), 32'h1);
        chk("t5_pre_busy", 32'(busy), 32'h1);
        reset_dut();
        push_pkt(0, 1, 8'hE0, 1'b1);
        run_until_drained(30);
        chk("t5_count", 32'(wr_gid.size()), 32'd3);
        if (wr_gid.size() == 3) begin
            chk("t5_first_gid", 32'(wr_gid[0]), 32'd0);
            chk("t5_second_gid", 32'(wr_gid[1]), 32'd2);
            chk("t5_second_dat", 32'(wr_dat[1]), 32'hD3);
        end

        // stall counter saturation
        clear_tb();
        reset_dut();
        push_pkt(1, 1, 8'h77, 1'b1);
        full_lo = 0;
        full_hi = 70010;
        repeat (70005) step();
        chk("t6_sat", 32'(stall_cnt), 32'hFFFF);
        full_lo = 1;
        full_hi = 0;
        run_until_drained(20);
        chk("t6_sat_hold", 32'(stall_cnt), 32'hFFFF);
        chk("t6_count", 32'(wr_gid.size()), 32'd1);

        // randomized traffic against the model
        clear_tb();
        reset_dut();
        pct       = 70;
        rand_full = 1'b1;
        for (int p = 0; p < 60; p++)
            push_pkt($urandom_range(N - 1), $urandom_range(6, 1), W'($urandom), ($urandom_range(3) != 0));
        run_until_drained(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
